// File: rtl/fruta_spawner.sv
`timescale 1ns/1ps
// fruta_spawner
// Picks a new fruit cell for the snake game. When the update stage requests
// a spawn, the block draws pseudo-random coordinates from a free-running
// 16-bit Galois LFSR and reads each candidate cell through the map RAM read
// port. The first empty cell becomes the fruit. If MAX_TRIES random samples
// all land on occupied cells, it falls back to a row-major scan of the whole
// map. If the scan finds no empty cell, it reports fail.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   fruta_enable  single-cycle spawn request from the update stage
//   busy          high while a request is being serviced
//   rd_req        map read request (one cycle per read)
//   rd_x, rd_y    map read coordinates
//   rd_data       map cell contents, valid one cycle after rd_req (00 = empty)
//   fruta_wenable one-cycle pulse: fruta_wx/fruta_wy hold a new fruit position
//   fruta_wx/wy   fruit position, held until the next successful spawn
//   fail          one-cycle pulse: the map has no empty cell
module fruta_spawner #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter int          MAX_TRIES   = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fruta_enable,
  output logic       busy,
  output logic       rd_req,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  input  logic [1:0] rd_data,
  output logic       fruta_wenable,
  output logic [9:0] fruta_wx,
  output logic [9:0] fruta_wy,
  output logic       fail
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_C   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [9:0]  WIDTH_C  = 10'(MAPA_WIDTH);
  localparam logic [9:0]  HEIGHT_C = 10'(MAPA_HEIGHT);
  localparam logic [9:0]  LAST_X_C = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0]  LAST_Y_C = 10'(MAPA_HEIGHT - 1);
  localparam logic [7:0]  TRIES_C  = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SREAD = 3'd4,
    ST_SWAIT = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } state_t;

  // Galois step, taps x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t      state_r;
  logic [15:0] lfsr_r;
  logic [7:0]  tries_r;

  logic [9:0]  cx_s;
  logic [9:0]  cy_s;
  logic        in_range_s;
  logic [7:0]  tries_inc_s;
  logic        cell_empty_s;
  logic        scan_last_s;

  // Candidate draw: 6 bits of column (0..63) and 5 bits of row (0..31);
  // draws outside the map are simply skipped while the LFSR keeps moving.
  assign cx_s         = {4'b0000, lfsr_r[5:0]};
  assign cy_s         = {5'b00000, lfsr_r[12:8]};
  assign in_range_s   = (cx_s < WIDTH_C) && (cy_s < HEIGHT_C);
  assign tries_inc_s  = tries_r + 8'd1;
  assign cell_empty_s = (rd_data == 2'b00);
  assign scan_last_s  = (rd_x == LAST_X_C) && (rd_y == LAST_Y_C);

  // Spawn FSM, LFSR and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      lfsr_r        <= SEED_C;
      tries_r       <= 8'd0;
      busy          <= 1'b0;
      rd_req        <= 1'b0;
      rd_x          <= 10'd0;
      rd_y          <= 10'd0;
      fruta_wenable <= 1'b0;
      fruta_wx      <= 10'd0;
      fruta_wy      <= 10'd0;
      fail          <= 1'b0;
    end else begin
      // The LFSR free-runs so the draw depends on when the request arrives.
      lfsr_r        <= lfsr_next(lfsr_r);
      fruta_wenable <= 1'b0;
      fail          <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (fruta_enable) begin
            busy    <= 1'b1;
            tries_r <= 8'd0;
            state_r <= ST_PICK;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_PICK: begin
          if (in_range_s) begin
            rd_x    <= cx_s;
            rd_y    <= cy_s;
            rd_req  <= 1'b1;
            state_r <= ST_READ;
          end else begin
            state_r <= ST_PICK;
          end
        end

        ST_READ: begin
          rd_req  <= 1'b0;
          state_r <= ST_WAIT;
        end

        // rd_data now answers the random read issued in READ.
        ST_WAIT: begin
          if (cell_empty_s) begin
            state_r <= ST_DONE;
          end else if (tries_inc_s == TRIES_C) begin
            tries_r <= tries_inc_s;
            rd_x    <= 10'd0;
            rd_y    <= 10'd0;
            rd_req  <= 1'b1;
            state_r <= ST_SREAD;
          end else begin
            tries_r <= tries_inc_s;
            state_r <= ST_PICK;
          end
        end

        ST_SREAD: begin
          rd_req  <= 1'b0;
          state_r <= ST_SWAIT;
        end

        // rd_data now answers the scan read at (rd_x, rd_y).
        ST_SWAIT: begin
          if (cell_empty_s) begin
            state_r <= ST_DONE;
          end else if (scan_last_s) begin
            state_r <= ST_FAIL;
          end else begin
            if (rd_x == LAST_X_C) begin
              rd_x <= 10'd0;
              rd_y <= rd_y + 10'd1;
            end else begin
              rd_x <= rd_x + 10'd1;
            end
            rd_req  <= 1'b1;
            state_r <= ST_SREAD;
          end
        end

        ST_DONE: begin
          fruta_wenable <= 1'b1;
          fruta_wx      <= rd_x;
          fruta_wy      <= rd_y;
          busy          <= 1'b0;
          state_r       <= ST_IDLE;
        end

        ST_FAIL: begin
          fail    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          rd_req  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fruta_spawner.sv
`timescale 1ns/1ps
// tb_fruta_spawner
// Directed bench for fruta_spawner (built with MAX_TRIES = 4). A small map
// model answers reads; a reference LFSR tracks the free-running generator so
// the expected fruit position and latency of random spawns can be predicted.
module tb_fruta_spawner;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int TRIES = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fruta_enable = 1'b0;
  logic [1:0] rd_data = 2'b00;
  logic       busy, rd_req, fruta_wenable, fail;
  logic [9:0] rd_x, rd_y, fruta_wx, fruta_wy;

  int total = 0;
  int bad = 0;

  // Map model controls, written only by the stimulus process.
  int map_mode = 0;   // 0 empty, 1 first map_occ reads occupied, 2 only (39,29) empty after random reads, 3 full
  int map_occ = 0;
  int reads_cnt = 0;

  logic [15:0] m_lfsr;

  // Results of the last request.
  int r_reads, r_lat, r_busy_bad, r_scan_bad, r_both, r_post, r_x, r_y;
  bit r_we, r_fail, r_busy_end, r_done;
  logic [15:0] r_snap;

  typedef struct {
    int mode;
    int occ;
    bit rep;
    bit exp_fail;
    int exp_reads;
    bit use_model;
    int ex;
    int ey;
  } vec_t;

  vec_t tbl[6];

  fruta_spawner #(.MAX_TRIES(TRIES)) dut (
    .clk(clk), .reset(reset), .fruta_enable(fruta_enable), .busy(busy),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .fruta_wenable(fruta_wenable), .fruta_wx(fruta_wx), .fruta_wy(fruta_wy),
    .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nx(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference generator: reloads on reset, steps on every clock.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= nx(m_lfsr);
  end

  // Map RAM model: one-cycle read latency; reads_cnt was already bumped for this read.
  always @(posedge clk) begin
    if (rd_req) begin
      case (map_mode)
        0: rd_data <= 2'b00;
        1: rd_data <= ((reads_cnt - 1) < map_occ) ? 2'b01 : 2'b00;
        2: begin
          if ((reads_cnt - 1) < TRIES)                 rd_data <= 2'b01;
          else if (rd_x == 10'd39 && rd_y == 10'd29)   rd_data <= 2'b00;
          else                                         rd_data <= 2'b01;
        end
        default: rd_data <= 2'b11;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Predicts the fruit and latency given the LFSR value in the first PICK cycle.
  function automatic void predict(input logic [15:0] v0, input int occ,
                                  output int px, output int py, output int lat);
    logic [15:0] v;
    int t;
    int k;
    v = v0; t = 0; k = 0; px = -1; py = -1; lat = -1;
    for (int n = 0; n < 100000; n++) begin
      if (!(v[5:0] < 6'd40 && v[12:8] < 5'd30)) begin
        v = nx(v); t++;
      end else if (k < occ) begin
        v = nx(nx(nx(v))); t += 3; k++;
      end else begin
        px = int'(v[5:0]); py = int'(v[12:8]); lat = t + 4;
        break;
      end
    end
  endfunction

  // Issues one request and watches it to completion, then 10 quiet cycles.
  task automatic do_req(input int mode, input int occ, input bit rep);
    map_mode = mode; map_occ = occ; reads_cnt = 0;
    r_reads = 0; r_lat = -1; r_busy_bad = 0; r_scan_bad = 0; r_both = 0; r_post = 0;
    r_we = 0; r_fail = 0; r_busy_end = 1; r_done = 0; r_x = -1; r_y = -1;
    @(negedge clk); fruta_enable = 1'b1;
    @(negedge clk); fruta_enable = 1'b0;
    r_snap = m_lfsr;
    for (int c = 0; c < 6000; c++) begin
      if (rep && c == 1) fruta_enable = 1'b1;
      else if (rep && c == 2) fruta_enable = 1'b0;
      if (rd_req) begin
        if (reads_cnt >= TRIES) begin
          if (int'(rd_x) != (reads_cnt - TRIES) % W || int'(rd_y) != (reads_cnt - TRIES) / W)
            r_scan_bad++;
        end
        reads_cnt++;
      end
      if (fruta_wenable && fail) r_both++;
      if (fruta_wenable || fail) begin
        r_we = fruta_wenable; r_fail = fail; r_lat = c;
        r_x = int'(fruta_wx); r_y = int'(fruta_wy); r_busy_end = busy; r_done = 1;
        break;
      end
      if (!busy) r_busy_bad++;
      @(negedge clk);
    end
    fruta_enable = 1'b0;
    r_reads = reads_cnt;
    repeat (10) begin
      @(negedge clk);
      if (fruta_wenable || fail || busy || rd_req) r_post++;
    end
  endtask

  initial begin
    logic [15:0] gold [6];
    int act, px, py, pl;
    bit found;
    gold[0] = 16'hE270; gold[1] = 16'h7138; gold[2] = 16'h389C;
    gold[3] = 16'h1C4E; gold[4] = 16'h0E27; gold[5] = 16'hB313;

    //            mode occ rep fail reads model ex  ey
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1,    1'b1, 0,  0};
    tbl[1] = '{1, 3, 1'b0, 1'b0, 4,    1'b1, 0,  0};
    tbl[2] = '{1, 1, 1'b0, 1'b0, 2,    1'b1, 0,  0};
    tbl[3] = '{2, 0, 1'b0, 1'b0, 1204, 1'b0, 39, 29};
    tbl[4] = '{3, 0, 1'b0, 1'b1, 1204, 1'b0, 39, 29};
    tbl[5] = '{0, 0, 1'b1, 1'b0, 1,    1'b1, 0,  0};

    // Reset state and LFSR sequence.
    repeat (3) @(negedge clk);
    chk("reset_flags", int'({busy, rd_req, fruta_wenable, fail}), 0);
    chk("reset_coords", int'(rd_x | rd_y | fruta_wx | fruta_wy), 0);
    chk("reset_lfsr", int'(dut.lfsr_r), 16'hACE1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lfsr_seq", int'(dut.lfsr_r), int'(gold[i]));
    end
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || rd_req || fruta_wenable || fail || (rd_x | rd_y | fruta_wx | fruta_wy) != 10'd0) act++;
    end
    chk("idle_quiet", act, 0);

    // Table-driven requests.
    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].mode, tbl[i].occ, tbl[i].rep);
      chk("done_in_time", int'(r_done), 1);
      chk("wenable_seen", int'(r_we), int'(!tbl[i].exp_fail));
      chk("fail_seen", int'(r_fail), int'(tbl[i].exp_fail));
      chk("read_count", r_reads, tbl[i].exp_reads);
      chk("we_fail_overlap", r_both, 0);
      chk("busy_during", r_busy_bad, 0);
      chk("busy_at_end", int'(r_busy_end), 0);
      chk("quiet_after", r_post, 0);
      chk("scan_order", r_scan_bad, 0);
      if (tbl[i].use_model) begin
        predict(r_snap, tbl[i].occ, px, py, pl);
        chk("fruit_x", r_x, px);
        chk("fruit_y", r_y, py);
        chk("latency", r_lat, pl);
        chk("fruit_in_map", int'(r_x < W && r_y < H), 1);
      end else begin
        chk("fruit_x_fixed", r_x, tbl[i].ex);
        chk("fruit_y_fixed", r_y, tbl[i].ey);
      end
    end

    // Reset while the random read is being evaluated.
    map_mode = 0; map_occ = 0; reads_cnt = 0;
    @(negedge clk); fruta_enable = 1'b1;
    @(negedge clk); fruta_enable = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rd_req) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_read", int'(found), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_flags", int'({busy, rd_req, fruta_wenable, fail}), 0);
    chk("rst_mid_lfsr", int'(dut.lfsr_r), 16'hACE1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || rd_req || fruta_wenable || fail) act++;
    end
    chk("rst_no_pulse", act, 0);
    chk("rst_coords", int'(rd_x | rd_y | fruta_wx | fruta_wy), 0);

    do_req(0, 0, 1'b0);
    predict(r_snap, 0, px, py, pl);
    chk("post_rst_we", int'(r_we), 1);
    chk("post_rst_x", r_x, px);
    chk("post_rst_y", r_y, py);
    chk("post_rst_lat", r_lat, pl);
    chk("post_rst_reads", r_reads, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
